trg_mon_frame: RTL

- Parametrised successor of the telemetry monitor readout block. Snapshots N_CH 16-bit monitor channels (counters and config words from ConfigReg, HitTrgCount, Coincidence) into a coherent frozen image.
- Serves the image two ways:
  - random-access register reads, as the telecommand/telemetry interface does today;
  - a new framed stream (header, frame counter, data, checksum) with a valid/ready handshake, for the packet builder.

---
 rtl/trg_mon_pkg.sv | 33 +++
 rtl/trg_mon_chksum.sv | 62 ++++++
 rtl/trg_mon_frame.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/trg_mon_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : trg_mon_pkg
//  Purpose  : Shared types and constants for the trigger monitor frame block:
//             default sync word, stream FSM states, address offset helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package trg_mon_pkg;

  // Default frame header word, also readable just past the checksum address
  localparam logic [15:0] SYNC_WORD_DEF = 16'hEB90;

  // Stream FSM states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_CNT  = 3'd2,
    ST_DATA = 3'd3,
    ST_CHK  = 3'd4
  } frm_state_e;

  // Offset (from BASE_ADDR) of the last completed checksum register
  function automatic int chk_ofs(input int n_ch);
    return n_ch;
  endfunction

  // Offset (from BASE_ADDR) of the read-only sync word
  function automatic int sync_ofs(input int n_ch);
    return n_ch + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trg_mon_chksum.sv
`default_nettype none
// ============================================================================
//  Module   : trg_mon_chksum
//  Purpose  : Sequential mod-2^16 sum of the frozen image, one channel per
//             cycle. A start pulse (re)launches the sum; the result register
//             only changes when a full pass over all channels completes.
//  Revision : 1.0 - initial release
// ============================================================================
module trg_mon_chksum
  import trg_mon_pkg::*;
#(
  parameter int N_CH = 34
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [N_CH*16-1:0] image_i,
  output logic [15:0]        sum_o
);

  localparam logic [7:0] LAST_IDX = 8'(N_CH - 1);

  logic        active_q;
  logic [7:0]  idx_q;
  logic [15:0] acc_q;
  logic [15:0] sum_q;
  logic [15:0] word;

  // Select the image word addressed by the running channel index
  always_comb begin
    word = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (idx_q == 8'(i)) word = image_i[i*16 +: 16];
    end
  end

  // Accumulate one word per cycle; publish the sum only after the last channel
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      idx_q    <= '0;
      acc_q    <= '0;
      sum_q    <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      idx_q    <= '0;
      acc_q    <= '0;
    end else if (active_q) begin
      if (idx_q == LAST_IDX) begin
        sum_q    <= acc_q + word;
        active_q <= 1'b0;
      end else begin
        acc_q <= acc_q + word;
        idx_q <= idx_q + 8'd1;
      end
    end
  end

  assign sum_o = sum_q;

endmodule
`default_nettype wire

// File: rtl/trg_mon_frame.sv
`default_nettype none
// ============================================================================
//  Module   : trg_mon_frame
//  Purpose  : Snapshots N_CH 16-bit monitor channels into a frozen image and
//             serves it by random-access register reads and as a framed
//             valid/ready stream (sync, frame count, data, checksum).
//  Revision : 1.0 - initial release
// ============================================================================
module trg_mon_frame
  import trg_mon_pkg::*;
#(
  parameter int          N_CH      = 34,
  parameter logic [7:0]  BASE_ADDR = 8'h19,
  parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEF
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [N_CH*16-1:0] mon_vec_in,
  input  logic               rd_in,
  input  logic [7:0]         rd_addr_in,
  output logic [15:0]        mon_data_out,
  input  logic               frame_req_in,
  output logic [15:0]        frm_data_out,
  output logic               frm_valid_out,
  input  logic               frm_ready_in,
  output logic               frm_last_out,
  output logic               frame_busy_out,
  output logic [15:0]        snap_cnt_out,
  output logic [7:0]         req_drop_cnt_out
);

  localparam logic [8:0] DATA_END = 9'(N_CH);
  localparam logic [8:0] CHK_OFS  = 9'(chk_ofs(N_CH));
  localparam logic [8:0] SYNC_OFS = 9'(sync_ofs(N_CH));
  localparam logic [7:0] N_WORDS  = 8'(N_CH);

  // Registered state
  logic               rd_q;
  logic [N_CH*16-1:0] image_q;
  logic [15:0]        snap_cnt_q;
  logic [7:0]         drop_cnt_q;
  logic [15:0]        mon_data_q;
  frm_state_e         state_q;
  logic [7:0]         widx_q;
  logic [15:0]        frm_data_q;
  logic               frm_valid_q;
  logic               frm_last_q;
  logic               busy_q;
  logic [15:0]        frame_cnt_q;

  // Combinational helpers
  logic        rd_edge;
  logic        frame_start;
  logic        snap_take;
  logic        frm_adv;
  logic [8:0]  addr_ofs;
  logic [15:0] img_rd_word;
  logic [15:0] img_frm_word;
  logic [15:0] rd_word_d;
  logic [15:0] chk_sum;

  assign rd_edge     = rd_in & ~rd_q & (rd_addr_in == BASE_ADDR);
  assign frame_start = frame_req_in & (state_q == ST_IDLE);
  // The image is frozen for the whole frame, so a read edge only snapshots when idle
  assign snap_take   = frame_start | (rd_edge & ~busy_q);
  assign frm_adv     = frm_valid_q & frm_ready_in;
  // Addresses below BASE_ADDR wrap to >= 256 and therefore match nothing
  assign addr_ofs    = {1'b0, rd_addr_in} - {1'b0, BASE_ADDR};

  trg_mon_chksum #(
    .N_CH(N_CH)
  ) u_chksum (
    .clk_i  (clk_in),
    .rst_ni (rst_in),
    .start_i(snap_take),
    .image_i(image_q),
    .sum_o  (chk_sum)
  );

  // Image word muxes for the register read path and the stream path
  always_comb begin
    img_rd_word  = '0;
    img_frm_word = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (addr_ofs == 9'(i)) img_rd_word  = image_q[i*16 +: 16];
      if (widx_q   == 8'(i)) img_frm_word = image_q[i*16 +: 16];
    end
  end

  // Read data select; a snapshotting read of channel 0 returns the live value
  always_comb begin
    rd_word_d = mon_data_q;
    if (snap_take && (addr_ofs == 9'd0)) rd_word_d = mon_vec_in[15:0];
    else if (addr_ofs < DATA_END)        rd_word_d = img_rd_word;
    else if (addr_ofs == CHK_OFS)        rd_word_d = chk_sum;
    else if (addr_ofs == SYNC_OFS)       rd_word_d = SYNC_WORD;
  end

  // Snapshot capture, read-edge history and snapshot / dropped-request counters
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_q       <= 1'b0;
      image_q    <= '0;
      snap_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      rd_q <= rd_in;
      if (snap_take) begin
        image_q    <= mon_vec_in;
        snap_cnt_q <= snap_cnt_q + 16'd1;
      end
      if (frame_req_in && busy_q && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  // Register read port: one-cycle latency, holds on unmapped addresses
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mon_data_q <= '0;
    end else if (rd_in) begin
      mon_data_q <= rd_word_d;
    end
  end

  // Stream FSM: header, frame count, image words, checksum; advances on valid & ready
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= ST_IDLE;
      widx_q      <= '0;
      frm_data_q  <= '0;
      frm_valid_q <= 1'b0;
      frm_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (frame_req_in) begin
            state_q     <= ST_HDR;
            widx_q      <= '0;
            frm_data_q  <= SYNC_WORD;
            frm_valid_q <= 1'b1;
            frm_last_q  <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        ST_HDR: begin
          if (frm_adv) begin
            state_q    <= ST_CNT;
            frm_data_q <= frame_cnt_q;
          end
        end
        ST_CNT: begin
          if (frm_adv) begin
            state_q    <= ST_DATA;
            frm_data_q <= img_frm_word;
            widx_q     <= 8'd1;
          end
        end
        ST_DATA: begin
          if (frm_adv) begin
            // The checksum finished long before this point, so the register is current
            if (widx_q == N_WORDS) begin
              state_q    <= ST_CHK;
              frm_data_q <= chk_sum;
              frm_last_q <= 1'b1;
            end else begin
              frm_data_q <= img_frm_word;
              widx_q     <= widx_q + 8'd1;
            end
          end
        end
        ST_CHK: begin
          if (frm_adv) begin
            state_q     <= ST_IDLE;
            frm_valid_q <= 1'b0;
            frm_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= frame_cnt_q + 16'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mon_data_out     = mon_data_q;
  assign frm_data_out     = frm_data_q;
  assign frm_valid_out    = frm_valid_q;
  assign frm_last_out     = frm_last_q;
  assign frame_busy_out   = busy_q;
  assign snap_cnt_out     = snap_cnt_q;
  assign req_drop_cnt_out = drop_cnt_q;

endmodule
`default_nettype wire
